// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream push, kill/flush controls and downstream pop.
// The master side is whoever drives the stage; the slave side is the stage itself.
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              kill;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_ctrl, in_data, kill, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, kill, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with skid buffer: in_ready is decoded from registered state only,
// so no combinational path exists from out_ready back to in_ready.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CTRL_W   = 8,
  parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
  input logic            clk,
  input logic            rst_n,
  pipe_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] in_data_k;
  logic [CTRL_W-1:0] in_ctrl_k;
  logic              accept;
  logic              take;

  // rdy_q holds in_ready low during reset and until the first edge after release.
  assign bus.in_ready  = rdy_q & (state_q != StFull);
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.occupancy = 2'(state_q);

  assign accept    = bus.in_valid & bus.in_ready;
  assign take      = bus.out_valid & bus.out_ready;
  assign in_data_k = bus.kill ? NOP_DATA : bus.in_data;
  assign in_ctrl_k = bus.kill ? '0 : bus.in_ctrl;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (bus.flush) begin
      // Anything accepted this cycle is dropped; a coincident take has already completed.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StBusy;
            main_data_d = in_data_k;
            main_ctrl_d = in_ctrl_k;
          end
        end
        StBusy: begin
          if (accept && take) begin
            main_data_d = in_data_k;
            main_ctrl_d = in_ctrl_k;
          end else if (accept) begin
            state_d     = StFull;
            skid_data_d = in_data_k;
            skid_ctrl_d = in_ctrl_k;
          end else if (take) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (take) begin
            state_d     = StBusy;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      rdy_q       <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized bench for pipe_skid_reg: a FIFO-of-two queue model predicts every output
// after each clock edge, plus directed reset, kill, flush and ordering scenarios.
module tb_pipe_skid_reg;

  localparam int unsigned    DataW = 32;
  localparam int unsigned    CtrlW = 8;
  localparam logic [31:0]    NopData = 32'hDEAD_BEEF;

  logic clk;
  logic rst_n;

  pipe_skid_reg_if #(.DATA_W(DataW), .CTRL_W(CtrlW)) bus ();

  pipe_skid_reg #(
    .DATA_W   (DataW),
    .CTRL_W   (CtrlW),
    .NOP_DATA (NopData)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: ordered list of held {ctrl, data} entries, capacity two.
  logic [39:0] mq[$];
  logic        m_rdy;
  logic [31:0] taken[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_occ"}, 64'(bus.occupancy), 64'(mq.size()));
    check({tag, "_ovalid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
    check({tag, "_iready"}, 64'(bus.in_ready), 64'(m_rdy && mq.size() < 2));
    if (mq.size() != 0) begin
      check({tag, "_odata"}, 64'(bus.out_data), 64'(mq[0][31:0]));
      check({tag, "_octrl"}, 64'(bus.out_ctrl), 64'(mq[0][39:32]));
    end
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic [31:0] d,
                      input logic k, input logic f, input logic r, output logic acc);
    logic tk;
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.kill      = k;
    bus.flush     = f;
    bus.out_ready = r;
    #1;
    acc = v && m_rdy && (mq.size() < 2);
    tk  = (mq.size() != 0) && r;
    check("pre_iready", 64'(bus.in_ready), 64'(m_rdy && mq.size() < 2));
    if (bus.out_valid && r) taken.push_back(bus.out_data);
    @(posedge clk);
    if (f) begin
      mq.delete();
    end else begin
      if (tk) void'(mq.pop_front());
      if (acc) mq.push_back(k ? {8'h00, NopData} : {c, d});
    end
    m_rdy = 1'b1;
    #1;
    check_outputs("post");
  endtask

  task automatic idle(input logic r, input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, r, acc);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ovalid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_occ"}, 64'(bus.occupancy), 64'd0);
    check({tag, "_iready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_odata"}, 64'(bus.out_data), 64'd0);
    check({tag, "_octrl"}, 64'(bus.out_ctrl), 64'd0);
  endtask

  initial begin
    logic acc;
    int   idx;
    int   iter;
    int   ff_seen;

    rst_n = 1'b0;
    m_rdy = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ctrl   = '0;
    bus.in_data   = '0;
    bus.kill      = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #8;
    reset_checks("rst");
    #4 rst_n = 1'b1;

    // First edge after release only raises in_ready; then a single entry with 1-cycle latency.
    idle(1'b1, 1);
    step(1'b1, 8'h01, 32'h11, 1'b0, 1'b0, 1'b1, acc);
    check("lat_data", 64'(bus.out_data), 64'h11);
    idle(1'b1, 1);
    check("lat_gone", 64'(bus.out_valid), 64'd0);

    // Fill to FULL with a stalled consumer, then drain in order.
    step(1'b1, 8'h0A, 32'hA1, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h0B, 32'hA2, 1'b0, 1'b0, 1'b0, acc);
    check("full_occ", 64'(bus.occupancy), 64'd2);
    check("full_head", 64'(bus.out_data), 64'hA1);
    taken.delete();
    idle(1'b1, 3);
    check("drain_n", 64'(taken.size()), 64'd2);
    if (taken.size() == 2) begin
      check("drain_0", 64'(taken[0]), 64'hA1);
      check("drain_1", 64'(taken[1]), 64'hA2);
    end

    // Kill converts the accepted entry into a NOP but keeps it valid.
    step(1'b1, 8'h5A, 32'h1234, 1'b1, 1'b0, 1'b0, acc);
    check("kill_data", 64'(bus.out_data), 64'(NopData));
    check("kill_ctrl", 64'(bus.out_ctrl), 64'd0);
    step(1'b0, 8'h33, 32'h55, 1'b1, 1'b0, 1'b1, acc);

    // Flush from FULL with a coincident push: the pushed 0xFF must never emerge.
    step(1'b1, 8'h01, 32'hB1, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h02, 32'hB2, 1'b0, 1'b0, 1'b0, acc);
    taken.delete();
    step(1'b1, 8'hFF, 32'hFF, 1'b0, 1'b1, 1'b0, acc);
    check("flush_occ", 64'(bus.occupancy), 64'd0);
    idle(1'b1, 3);
    ff_seen = 0;
    foreach (taken[i]) if (taken[i] == 32'hFF) ff_seen++;
    check("flush_no_ff", 64'(ff_seen), 64'd0);

    // Ordered stream 1..16 against a randomly stalling consumer.
    taken.delete();
    idx  = 1;
    iter = 0;
    while (idx <= 16 && iter < 400) begin
      step(1'b1, 8'($urandom), 32'(idx), 1'b0, 1'b0, 1'($urandom_range(0, 1)), acc);
      if (acc) idx++;
      iter++;
    end
    idle(1'b1, 4);
    check("stream_len", 64'(taken.size()), 64'd16);
    foreach (taken[i]) check("stream_seq", 64'(taken[i]), 64'(i + 1));

    // Asynchronous reset while FULL.
    step(1'b1, 8'h01, 32'hC1, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h02, 32'hC2, 1'b0, 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    mq.delete();
    m_rdy = 1'b0;
    #1;
    reset_checks("midrst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    taken.delete();
    step(1'b1, 8'h07, 32'h77, 1'b0, 1'b0, 1'b1, acc);
    check("midrst_noacc", 64'(acc), 64'd0);
    step(1'b1, 8'h07, 32'h77, 1'b0, 1'b0, 1'b0, acc);
    check("midrst_first", 64'(bus.out_data), 64'h77);
    check("midrst_alone", 64'(bus.occupancy), 64'd1);
    idle(1'b1, 2);
    check("midrst_taken", 64'(taken.size()), 64'd1);

    // Random traffic with occasional kill and flush.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), acc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
